// File: rtl/usb_ep_pump.sv
// USB endpoint pump: writes a pattern, a counter sequence or looped-back OUT data
// into an IN endpoint, with burst length control, abort and saturating byte counters.
module usb_ep_pump #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int CW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      mode_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [CW-1:0]   burst_len_i,
  input  logic [4*DW-1:0] pat_i,
  output logic [DW-1:0]   in_din_o,
  output logic            in_we_o,
  input  logic            in_full_i,
  input  logic [DW-1:0]   out_dout_i,
  output logic            out_re_o,
  input  logic            out_empty_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [CW-1:0]   tx_count_o,
  output logic [CW-1:0]   rx_count_o,
  output logic [7:0]      led_o
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [1:0] M_PAT  = 2'd1;
  localparam logic [1:0] M_CNT  = 2'd2;
  localparam logic [1:0] M_LOOP = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        mode_reg;
  logic [CW-1:0]     burst_len_reg;
  logic [4*DW-1:0]   pat_reg;
  logic [1:0]        pat_idx_reg;
  logic [DW-1:0]     cnt_byte_reg;
  logic [CW-1:0]     tx_cnt_reg, rx_cnt_reg;
  logic              rd_pending_reg;
  logic              done_seen_reg;
  logic              ovf_reg;
  logic [DW-1:0]     fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       fifo_cnt_reg;
  logic [DW-1:0]     pat_word [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pat
      assign pat_word[gi] = pat_reg[gi*DW +: DW];
    end
  endgenerate

  logic          start_ok, is_loop, fifo_empty, fifo_full, byte_avail, wr_fire;
  logic          last_write, push_req, push_ok, pop, flush;
  logic [AW:0]   fifo_free;
  logic [CW-1:0] tx_cnt_inc;
  logic [DW-1:0] src_byte;

  assign start_ok   = (state_reg == S_IDLE) && start_i && !abort_i && (mode_i != 2'd0);
  assign is_loop    = (mode_reg == M_LOOP);
  assign fifo_empty = (fifo_cnt_reg == '0);
  assign fifo_full  = (fifo_cnt_reg == (AW+1)'(DEPTH));
  assign fifo_free  = (AW+1)'(DEPTH) - fifo_cnt_reg;
  assign byte_avail = is_loop ? !fifo_empty : 1'b1;
  assign wr_fire    = (state_reg == S_RUN) && !in_full_i && byte_avail;
  assign tx_cnt_inc = (&tx_cnt_reg) ? tx_cnt_reg : tx_cnt_reg + CW'(1);
  assign last_write = wr_fire && (burst_len_reg != '0) && (tx_cnt_inc == burst_len_reg);

  always_comb begin
    src_byte = '0;
    case (mode_reg)
      M_PAT:   src_byte = pat_word[pat_idx_reg];
      M_CNT:   src_byte = cnt_byte_reg;
      M_LOOP:  src_byte = fifo_mem[rd_ptr_reg];
      default: src_byte = '0;
    endcase
  end

  assign in_we_o  = wr_fire;
  assign in_din_o = wr_fire ? src_byte : '0;
  // A read is only issued when the FIFO can still absorb every byte already requested.
  assign out_re_o = (state_reg == S_RUN) && is_loop && !out_empty_i &&
                    (fifo_free > (AW+1)'(rd_pending_reg));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_ok) state_next = S_RUN;
      S_RUN:   if (abort_i) state_next = S_IDLE;
               else if (last_write) state_next = S_DRAIN;
      // The outstanding read returns during this single cycle and is dropped.
      S_DRAIN: state_next = abort_i ? S_IDLE : S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= S_IDLE;
      mode_reg       <= '0;
      burst_len_reg  <= '0;
      pat_reg        <= '0;
      pat_idx_reg    <= '0;
      cnt_byte_reg   <= '0;
      tx_cnt_reg     <= '0;
      rx_cnt_reg     <= '0;
      rd_pending_reg <= 1'b0;
      done_seen_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rd_pending_reg <= out_re_o;
      if (start_ok) begin
        mode_reg      <= mode_i;
        burst_len_reg <= burst_len_i;
        pat_reg       <= pat_i;
        pat_idx_reg   <= '0;
        cnt_byte_reg  <= '0;
        tx_cnt_reg    <= '0;
        rx_cnt_reg    <= '0;
        done_seen_reg <= 1'b0;
      end else begin
        if (wr_fire) begin
          pat_idx_reg  <= pat_idx_reg + 2'd1;
          cnt_byte_reg <= cnt_byte_reg + DW'(1);
          tx_cnt_reg   <= tx_cnt_inc;
        end
        if (out_re_o && !(&rx_cnt_reg)) rx_cnt_reg <= rx_cnt_reg + CW'(1);
        if (state_reg == S_DONE) done_seen_reg <= 1'b1;
      end
    end
  end

  // Leaving RUN for any reason empties the FIFO; returned bytes only count while running.
  assign flush    = (state_next != S_RUN);
  assign push_req = rd_pending_reg && (state_reg == S_RUN) && !flush;
  assign push_ok  = push_req && !fifo_full;
  assign pop      = wr_fire && is_loop && !flush;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push_req && fifo_full) ovf_reg <= 1'b1;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_ok && !pop) fifo_cnt_reg <= fifo_cnt_reg + (AW+1)'(1);
      else if (!push_ok && pop) fifo_cnt_reg <= fifo_cnt_reg - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= out_dout_i;
  end

  assign busy_o     = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign done_o     = (state_reg == S_DONE);
  assign tx_count_o = tx_cnt_reg;
  assign rx_count_o = rx_cnt_reg;
  assign led_o      = {busy_o, done_seen_reg, ovf_reg, fifo_empty, fifo_full, 1'b0, mode_reg};

endmodule

// File: tb/tb_usb_ep_pump.sv
// Scoreboard bench for usb_ep_pump: expected IN bytes are queued from a simple
// reference model (pattern index, counter value, OUT byte order) and checked per write.
module tb_usb_ep_pump;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [1:0]      mode_i = '0;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic [CW-1:0]   burst_len_i = '0;
  logic [4*DW-1:0] pat_i = '0;
  logic [DW-1:0]   in_din_o;
  logic            in_we_o;
  logic            in_full_i = 1'b0;
  logic [DW-1:0]   out_dout_i = '0;
  logic            out_re_o;
  logic            out_empty_i = 1'b1;
  logic            busy_o, done_o;
  logic [CW-1:0]   tx_count_o, rx_count_o;
  logic [7:0]      led_o;

  usb_ep_pump #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .start_i(start_i), .abort_i(abort_i),
    .burst_len_i(burst_len_i), .pat_i(pat_i), .in_din_o(in_din_o), .in_we_o(in_we_o),
    .in_full_i(in_full_i), .out_dout_i(out_dout_i), .out_re_o(out_re_o),
    .out_empty_i(out_empty_i), .busy_o(busy_o), .done_o(done_o),
    .tx_count_o(tx_count_o), .rx_count_o(rx_count_o), .led_o(led_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int first_wr = -1, last_wr = 0, done_cyc = 0;
  int full_mode = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every IN write is compared with the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_i && in_we_o) begin
      chk("we_while_full", 32'(in_full_i), 32'd0);
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("in_din", 32'(in_din_o), 32'(exp_q.pop_front()));
      $display("wr %0d cyc %0d data %02h", wr_cnt, cyc, in_din_o);
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (rst_i && done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst_i && out_re_o) rd_cnt++;
  end

  // OUT endpoint model: data appears the cycle after a read strobe.
  always begin : out_model
    logic re;
    logic [DW-1:0] nxt;
    nxt = '0;
    @(negedge clk_i);
    re = out_re_o && rst_i;
    if (re) begin
      chk("read_nonempty", 32'(out_empty_i), 32'd0);
      if (out_q.size() != 0) nxt = out_q.pop_front();
    end
    @(posedge clk_i);
    #1;
    if (re) out_dout_i = nxt;
    out_empty_i = (out_q.size() == 0);
  end

  // IN endpoint backpressure generator.
  always begin : full_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (full_mode == 1) begin
        ph++;
        if (ph == 3) begin
          ph = 0;
          in_full_i = !in_full_i;
        end
      end else if (full_mode == 2) begin
        in_full_i = ($urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m, input int len, input logic [31:0] p);
    mode_i = m;
    burst_len_i = CW'(len);
    pat_i = p;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    mode_i = 2'($urandom_range(0, 3));
    burst_len_i = CW'($urandom);
    pat_i = $urandom;
  endtask

  task automatic push_model(input logic [1:0] m, input int len, input logic [31:0] p);
    for (int k = 0; k < len; k++) begin
      if (m == 2'd1) exp_q.push_back(p[(k % 4)*8 +: 8]);
      else exp_q.push_back(8'(k % 256));
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < bound) begin
      tick(1);
      n++;
    end
    chk(name, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int d0, r0, n;
    logic [31:0] p;
    int len;

    tick(3);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_we", 32'(in_we_o), 0);
    chk("rst_re", 32'(out_re_o), 0);
    chk("rst_tx", 32'(tx_count_o), 0);
    chk("rst_rx", 32'(rx_count_o), 0);
    chk("rst_led", 32'(led_o), 32'h10);
    rst_i = 1'b1;
    tick(2);

    // Start with mode 0 is ignored; abort beats start in IDLE.
    mode_i = 2'd0; start_i = 1'b1; tick(1); start_i = 1'b0;
    chk("mode0_ignored", 32'(busy_o), 0);
    mode_i = 2'd1; start_i = 1'b1; abort_i = 1'b1; tick(1); start_i = 1'b0; abort_i = 1'b0;
    chk("abort_beats_start", 32'(busy_o), 0);
    tick(3);
    chk("no_writes_idle", 32'(wr_cnt), 0);

    // Constant FA pattern, burst of 8.
    first_wr = -1; d0 = wr_cnt;
    push_model(2'd1, 8, 32'hFAFAFAFA);
    start_run(2'd1, 8, 32'hFAFAFAFA);
    wait_done("pat_done", 40);
    chk("pat_tx", 32'(tx_count_o), 8);
    chk("pat_writes", 32'(wr_cnt - d0), 8);
    chk("pat_consecutive", 32'(last_wr - first_wr), 7);
    chk("pat_done_latency", 32'(done_cyc - last_wr), 2);
    chk("pat_done_seen", 32'(led_o[6]), 1);
    chk("pat_queue_empty", 32'(exp_q.size()), 0);
    tick(1);
    chk("pat_idle", 32'(busy_o), 0);

    // Counter mode, 300 bytes, backpressure toggling every 3 cycles.
    full_mode = 1;
    push_model(2'd2, 300, 32'd0);
    start_run(2'd2, 300, 32'd0);
    wait_done("cnt_done", 2000);
    full_mode = 0; in_full_i = 1'b0;
    chk("cnt_tx", 32'(tx_count_o), 300);
    chk("cnt_rx", 32'(rx_count_o), 0);
    chk("cnt_queue_empty", 32'(exp_q.size()), 0);
    tick(2);

    // Random patterns with random backpressure and an ignored mid-run start.
    for (int t = 0; t < 3; t++) begin
      p = $urandom;
      len = int'($urandom_range(10, 40));
      full_mode = 2;
      push_model(2'd1, len, p);
      start_run(2'd1, len, p);
      tick(2);
      mode_i = 2'd2; start_i = 1'b1; tick(1); start_i = 1'b0;
      wait_done("rnd_done", 400);
      chk("rnd_tx", 32'(tx_count_o), 32'(len));
      chk("rnd_queue_empty", 32'(exp_q.size()), 0);
      tick(2);
    end
    full_mode = 0; in_full_i = 1'b0;
    tick(2);

    // Loopback of 20 OUT bytes 10..23.
    for (int k = 0; k < 20; k++) begin
      out_q.push_back(8'(8'h10 + k));
      exp_q.push_back(8'(8'h10 + k));
    end
    tick(1);
    start_run(2'd3, 20, 32'd0);
    wait_done("loop_done", 200);
    chk("loop_tx", 32'(tx_count_o), 20);
    chk("loop_rx", 32'(rx_count_o), 20);
    chk("loop_ovf", 32'(led_o[5]), 0);
    chk("loop_queue_empty", 32'(exp_q.size()), 0);
    tick(2);

    // Loopback backpressure: FIFO fills to 16, then drains in order.
    in_full_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      p = $urandom;
      out_q.push_back(p[7:0]);
      exp_q.push_back(p[7:0]);
    end
    tick(1);
    r0 = rd_cnt; d0 = done_cnt;
    start_run(2'd3, 0, 32'd0);
    tick(100);
    chk("bp_reads", 32'(rd_cnt - r0), 16);
    chk("bp_fifo_full", 32'(led_o[3]), 1);
    chk("bp_ovf", 32'(led_o[5]), 0);
    chk("bp_tx", 32'(tx_count_o), 0);
    chk("bp_rx", 32'(rx_count_o), 16);
    in_full_i = 1'b0;
    tick(120);
    chk("bp_queue_empty", 32'(exp_q.size()), 0);
    chk("bp_tx_all", 32'(tx_count_o), 40);
    chk("bp_rx_all", 32'(rx_count_o), 40);
    chk("bp_still_busy", 32'(busy_o), 1);
    abort_i = 1'b1; tick(1); abort_i = 1'b0;
    chk("bp_abort_idle", 32'(busy_o), 0);
    tick(2);
    chk("bp_no_done", 32'(done_cnt - d0), 0);
    chk("bp_tx_hold", 32'(tx_count_o), 40);

    // Abort with a read in flight.
    in_full_i = 1'b1;
    for (int k = 0; k < 8; k++) out_q.push_back(8'($urandom));
    tick(1);
    d0 = done_cnt;
    start_run(2'd3, 0, 32'd0);
    @(negedge clk_i);
    n = 0;
    while (!out_re_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    chk("abort_read_seen", 32'(out_re_o), 1);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    chk("abort_idle", 32'(busy_o), 0);
    chk("abort_fifo_empty", 32'(led_o[4]), 1);
    tick(2);
    chk("abort_fifo_still_empty", 32'(led_o[4]), 1);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_rx_hold", 32'(rx_count_o), 1);
    chk("abort_tx_hold", 32'(tx_count_o), 0);
    out_q.delete();
    exp_q.delete();
    in_full_i = 1'b0;
    tick(2);

    // Reset in the middle of a loopback run.
    for (int k = 0; k < 30; k++) begin
      p = $urandom;
      out_q.push_back(p[7:0]);
      exp_q.push_back(p[7:0]);
    end
    full_mode = 2;
    tick(1);
    start_run(2'd3, 0, 32'd0);
    tick(15);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    chk("mid_rst_we", 32'(in_we_o), 0);
    chk("mid_rst_re", 32'(out_re_o), 0);
    chk("mid_rst_din", 32'(in_din_o), 0);
    chk("mid_rst_tx", 32'(tx_count_o), 0);
    chk("mid_rst_rx", 32'(rx_count_o), 0);
    chk("mid_rst_led", 32'(led_o), 32'h10);
    full_mode = 0;
    tick(2);
    in_full_i = 1'b0;
    out_q.delete();
    exp_q.delete();
    rst_i = 1'b1;
    #1;
    chk("post_rst_busy", 32'(busy_o), 0);
    tick(2);
    chk("post_rst_idle", 32'(busy_o), 0);
    chk("post_rst_led", 32'(led_o), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
